// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the banked UART transmit buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: bank-state enum, reader-state enum, autoflush frame multiplier,
// and the frame-length helper used to size the autoflush idle timer.
package uart_buf_pkg;

  // Ownership of a bank: FREE/FILLING belong to the writer, READY/DRAINING
  // to the reader, so a bank is never touched by both sides in one cycle.
  typedef enum logic [1:0] {
    BANK_FREE     = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_READY    = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_FETCH = 3'd1,
    RD_START = 3'd2,
    RD_DATA  = 3'd3,
    RD_STOP  = 3'd4
  } rd_state_t;

  // Idle time before a partial bank is closed, measured in whole frames.
  localparam int unsigned AUTOFLUSH_FRAMES = 16;

  // Clock cycles taken by one frame on the line (start + data + stop).
  function automatic int unsigned frame_clks(input int unsigned cpb,
                                             input int unsigned data_w,
                                             input int unsigned stop_bits);
    return cpb * (data_w + 1 + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit timer, bit counter and shift register behind the reader's START/DATA/STOP states.
// Latency: line follows i_state combinationally from registers; data word sampled at end of START.
// Backpressure: none; the controlling FSM advances only on o_bit_end.
// Ports: i_clock/i_reset (sync, active high), i_state = reader state,
// i_data = word to send, o_bit_end = last cycle of current bit,
// o_data_last/o_stop_last = current bit is the final data/stop bit, o_tx = serial line.
module uart_tx_serializer
  import uart_buf_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  rd_state_t         i_state,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit_end,
  output logic              o_data_last,
  output logic              o_stop_last,
  output logic              o_tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  logic [TW-1:0]     r_timer;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_on_line;

  assign w_on_line   = (i_state == RD_START) || (i_state == RD_DATA) || (i_state == RD_STOP);
  assign o_bit_end   = w_on_line && (r_timer == TIMER_LAST);
  assign o_data_last = (r_bit_cnt == DATA_LAST);
  assign o_stop_last = (r_bit_cnt == STOP_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      // Timer idles at 0 outside the frame so START always gets a full bit.
      if (!w_on_line || o_bit_end) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      case (i_state)
        RD_START: begin
          // RAM data landed during FETCH and is stable; latch it for DATA.
          if (o_bit_end) begin
            r_shift   <= i_data;
            r_bit_cnt <= '0;
          end
        end
        RD_DATA: begin
          if (o_bit_end) begin
            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
            r_bit_cnt <= o_data_last ? '0 : r_bit_cnt + BW'(1);
          end
        end
        RD_STOP: begin
          if (o_bit_end) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (i_state)
      RD_START: o_tx = 1'b0;
      RD_DATA:  o_tx = r_shift[0];
      default:  o_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_banked_tx_buffer.sv
// UART transmitter fed by NUM_BANKS ping-pong RAM banks; writer fills, reader drains in READY order.
// Latency: READY bank -> start bit after 2 cycles (IDLE->FETCH->START); frames back-to-back with 1-cycle FETCH.
// Backpressure: none; words arriving at a READY/DRAINING bank are dropped and set sticky overflow.
// Ports: clock, reset (sync active high), data_in/data_in_valid (write), flush (close partial bank),
// uart_tx (idle high), overflow (sticky drop flag), busy (any bank not FREE or frame in flight).
// Optional: define UART_BUF_AUTOFLUSH_EN to close a FILLING bank after 16 idle frame-times.
module uart_banked_tx_buffer
  import uart_buf_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_BANKS    = 2,
  parameter int BANK_DEPTH   = 16384,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              flush,
  output logic              uart_tx,
  output logic              overflow,
  output logic              busy
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_BANKS);
  localparam logic [CW-1:0] FULL_CNT  = CW'(BANK_DEPTH);
  localparam logic [PW-1:0] LAST_BANK = PW'(NUM_BANKS - 1);

  bank_state_t       r_bank_state [NUM_BANKS];
  logic [CW-1:0]     r_fill_cnt   [NUM_BANKS];
  logic [DATA_W-1:0] w_bank_rdata [NUM_BANKS];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_rd_addr;
  logic              r_overflow;
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;

  logic              w_bit_end;
  logic              w_data_last;
  logic              w_stop_last;
  logic              w_start_drain;
  logic              w_frame_end;
  logic              w_more;
  logic              w_rd_free;
  logic              w_same_bank_free;
  bank_state_t       w_tgt_state;
  logic [CW-1:0]     w_tgt_cnt;
  logic [CW-1:0]     w_wr_cnt_next;
  logic              w_wr_ok;
  logic              w_close_req;
  logic              w_close;
  logic              w_drop;
  logic              w_auto_flush;
  logic              w_busy;

  // ---------------- reader decisions ----------------
  assign w_start_drain = (r_rd_state == RD_IDLE) && (r_bank_state[r_rd_ptr] == BANK_READY);
  assign w_frame_end   = (r_rd_state == RD_STOP) && w_bit_end && w_stop_last;
  assign w_more        = (({1'b0, r_rd_addr} + CW'(1)) < r_fill_cnt[r_rd_ptr]);
  assign w_rd_free     = w_frame_end && !w_more;

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (w_start_drain) w_rd_next = RD_FETCH;
      RD_FETCH: w_rd_next = RD_START;
      RD_START: if (w_bit_end) w_rd_next = RD_DATA;
      RD_DATA:  if (w_bit_end && w_data_last) w_rd_next = RD_STOP;
      RD_STOP:  if (w_frame_end) w_rd_next = w_more ? RD_FETCH : RD_IDLE;
      default:  w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
    end
  end

  // ---------------- writer decisions ----------------
  // A bank the reader releases on this edge is already FREE for the writer.
  assign w_same_bank_free = w_rd_free && (r_rd_ptr == r_wr_ptr);
  assign w_tgt_state      = w_same_bank_free ? BANK_FREE : r_bank_state[r_wr_ptr];
  assign w_tgt_cnt        = w_same_bank_free ? '0 : r_fill_cnt[r_wr_ptr];
  assign w_wr_cnt_next    = w_tgt_cnt + CW'(1);
  assign w_wr_ok          = data_in_valid &&
                            ((w_tgt_state == BANK_FREE) || (w_tgt_state == BANK_FILLING));
  assign w_drop           = data_in_valid && !w_wr_ok;
  assign w_close_req      = flush || w_auto_flush;
  // A flush alongside a write closes the bank with that word included.
  assign w_close          = w_wr_ok ? ((w_wr_cnt_next == FULL_CNT) || w_close_req)
                                    : (w_close_req && (w_tgt_state == BANK_FILLING));

`ifdef UART_BUF_AUTOFLUSH_EN
  localparam int unsigned AF_LIMIT = AUTOFLUSH_FRAMES * frame_clks(CLKS_PER_BIT, DATA_W, STOP_BITS);
  localparam int AFW = $clog2(AF_LIMIT);
  localparam logic [AFW-1:0] AF_LAST = AFW'(AF_LIMIT - 1);

  logic [AFW-1:0] r_idle_cnt;

  assign w_auto_flush = (w_tgt_state == BANK_FILLING) && !data_in_valid && (r_idle_cnt == AF_LAST);

  always_ff @(posedge clock) begin
    if (reset || data_in_valid || (w_tgt_state != BANK_FILLING) || w_auto_flush) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + AFW'(1);
    end
  end
`else
  assign w_auto_flush = 1'b0;
`endif

  // ---------------- bank bookkeeping ----------------
  // Reader updates come first so a same-edge writer update to the bank it
  // just released wins (FREE -> FILLING).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_bank_state[b] <= BANK_FREE;
        r_fill_cnt[b]   <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_addr  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start_drain) begin
        r_bank_state[r_rd_ptr] <= BANK_DRAINING;
        r_rd_addr              <= '0;
      end
      if (w_frame_end) begin
        if (w_more) begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end else begin
          r_bank_state[r_rd_ptr] <= BANK_FREE;
          r_fill_cnt[r_rd_ptr]   <= '0;
          r_rd_ptr               <= (r_rd_ptr == LAST_BANK) ? '0 : r_rd_ptr + PW'(1);
        end
      end

      if (w_wr_ok) begin
        r_fill_cnt[r_wr_ptr]   <= w_wr_cnt_next;
        r_bank_state[r_wr_ptr] <= w_close ? BANK_READY : BANK_FILLING;
      end else if (w_close) begin
        r_bank_state[r_wr_ptr] <= BANK_READY;
      end
      if (w_close) begin
        r_wr_ptr <= (r_wr_ptr == LAST_BANK) ? '0 : r_wr_ptr + PW'(1);
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------- bank RAMs: one single-port array each ----------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [BANK_DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_we;
    logic              w_re;
    logic [AW-1:0]     w_addr;

    assign w_we   = w_wr_ok && (r_wr_ptr == PW'(b));
    assign w_re   = (r_rd_state == RD_FETCH) && (r_rd_ptr == PW'(b));
    assign w_addr = w_we ? w_tgt_cnt[AW-1:0] : r_rd_addr;

    always_ff @(posedge clock) begin
      if (w_we) begin
        r_mem[w_addr] <= data_in;
      end else if (w_re) begin
        r_rdata <= r_mem[w_addr];
      end
    end

    assign w_bank_rdata[b] = r_rdata;
  end

  uart_tx_serializer #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_serializer (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_state     (r_rd_state),
    .i_data      (w_bank_rdata[r_rd_ptr]),
    .o_bit_end   (w_bit_end),
    .o_data_last (w_data_last),
    .o_stop_last (w_stop_last),
    .o_tx        (uart_tx)
  );

  always_comb begin
    w_busy = (r_rd_state != RD_IDLE);
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_bank_state[b] != BANK_FREE) w_busy = 1'b1;
    end
  end

  assign busy     = w_busy;
  assign overflow = r_overflow;

endmodule

// File: doc/uart_banked_tx_buffer.md
UART_BANKED_TX_BUFFER -- requirements
Module: uart_banked_tx_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART data bits per frame and buffer word width.
REQ-002 SHALL have parameter NUM_BANKS, default 2, number of single-port RAM banks (2..8).
REQ-003 SHALL have parameter BANK_DEPTH, default 16384, words per bank (power of two, >=4).
REQ-004 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (12 MHz to ~115200 baud; 13 gives ~921600).
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-006 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port data_in, input, DATA_W, write data.
REQ-009 SHALL have port data_in_valid, input, 1, write strobe, one word per asserted cycle.
REQ-010 SHALL have port flush, input, 1, single-cycle request to close a partially filled bank.
REQ-011 SHALL have port uart_tx, output, 1, serial line, idle high.
REQ-012 SHALL have port overflow, output, 1, sticky flag: at least one word was dropped.
REQ-013 SHALL have port busy, output, 1, high while any bank is not FREE or a frame is in flight.

Function
REQ-014 Each bank SHALL hold one state from FREE, FILLING, READY or DRAINING, plus a fill count of $clog2(BANK_DEPTH)+1 bits.
REQ-015 Writer SHALL target bank write_ptr; on data_in_valid with the target FREE or FILLING it SHALL store the word at address fill count, increment the count and set the state to FILLING.
REQ-016 When the count reaches BANK_DEPTH, the bank SHALL become READY on the same edge and write_ptr SHALL advance modulo NUM_BANKS.
REQ-017 On data_in_valid with the target READY or DRAINING, the word SHALL be dropped and overflow set; no other state changes.
REQ-018 flush with the target FILLING SHALL make it READY with its current count and advance write_ptr; flush with the target FREE is a no-op.
REQ-019 flush coinciding with data_in_valid SHALL store the word first, then close the bank including that word.
REQ-020 Reader SHALL drain banks strictly in the order they became READY, via read_ptr modulo NUM_BANKS.
REQ-021 Reader FSM states: IDLE, FETCH, START, DATA, STOP.
- IDLE -> FETCH when bank read_ptr is READY (bank -> DRAINING).
- FETCH: 1-cycle RAM read latency.
- START: 1 bit-time low. DATA: DATA_W bits, LSB first. STOP: STOP_BITS bit-times high.
REQ-022 After STOP, the reader SHALL go to FETCH if words remain; otherwise the bank SHALL become FREE with count 0, read_ptr SHALL advance and the reader SHALL return to IDLE.
REQ-023 A bank SHALL never be accessed by writer and reader in the same cycle; this is guaranteed by the exclusive states.
REQ-024 Back-to-back frames SHALL have no idle gap beyond the 1-cycle FETCH.
REQ-025 The bit timer SHALL count 0..CLKS_PER_BIT-1 and advance the bit on terminal count.
REQ-026 A bank freed and written on the same edge SHALL accept the write (FREE→FILLING).

Reset
REQ-027 reset SHALL set all banks FREE, counts 0, both pointers 0, the reader to IDLE, uart_tx=1, overflow=0 and busy=0 on the next edge; RAM contents are not cleared.
REQ-028 reset asserted mid-frame SHALL abort the frame and drive uart_tx high the following cycle.

Configuration
REQ-029 With UART_BUF_AUTOFLUSH_EN defined, a FILLING bank with no data_in_valid for 16*CLKS_PER_BIT*(DATA_W+1+STOP_BITS) cycles SHALL be closed as if flushed; the timer resets on each write and on reset.
REQ-030 Without UART_BUF_AUTOFLUSH_EN, no timer logic SHALL exist and partial banks close only on flush.

Structure
REQ-031 Package uart_buf_pkg SHALL hold the bank-state and reader-state enums plus the frame-length helper constant.
REQ-032 Sub-module uart_tx_serializer (START/DATA/STOP and bit timer) SHALL be instantiated once; bank RAMs SHALL be inferred single-port arrays, one per bank.

Verification
REQ-033 Params DATA_W=8, NUM_BANKS=2, BANK_DEPTH=4, CLKS_PER_BIT=4. Write 0x01..0x04 back-to-back -> frames 0x01..0x04 in order, each 40 cycles, overflow=0.
REQ-034 Same params, write 10 words 0x10..0x19 in 10 cycles -> 0x10..0x17 transmitted, 0x18/0x19 dropped, overflow=1 until reset.
REQ-035 Write 0xA5, 0x3C then flush -> exactly two frames; line 0 1 0 1 0 0 1 0 1 1 for 0xA5; then busy=0.
REQ-036 Write 0x55 with flush in the same cycle -> one frame 0x55 transmitted.
REQ-037 Assert reset during DATA bit 3 -> uart_tx=1 next cycle, busy=0, subsequent write 0x01 + flush transmits a single frame 0x01.
REQ-038 With UART_BUF_AUTOFLUSH_EN and 1 write of 0x7E, no flush -> frame starts 640 cycles after the write; without the macro -> no frame, busy=1.
